// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Desc     : Shared stage indices, forward-select encoding and entry widths
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int STG_EX = 0;
    localparam int STG_ME = 1;
    localparam int STG_WB = 2;

    // Forward select value meaning "take the register file read data"
    localparam int SEL_RF = 0;

    localparam int ENT_V_W   = 1;
    localparam int ENT_WEN_W = 1;
    localparam int ENT_LD_W  = 1;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_fwd_mux
// Desc     : Youngest-producer match and operand mux for one ID source
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_fwd_mux
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(NSTAGE + 1)
) (
    input  logic [REG_AW-1:0]        rs,
    input  logic                     rs_used,
    input  logic [NSTAGE-1:0]        ent_v,
    input  logic [NSTAGE-1:0]        ent_wen,
    input  logic [NSTAGE-1:0]        ent_ld,
    input  logic [NSTAGE*REG_AW-1:0] ent_rd,
    input  logic [NSTAGE*XLEN-1:0]   stage_data,
    input  logic [XLEN-1:0]          rf_data,
    output logic [XLEN-1:0]          fwd_data,
    output logic [SEL_W-1:0]         fwd_sel,
    output logic                     not_ready
);

    logic [NSTAGE-1:0] w_match;
    logic              w_hit;
    logic              w_ready;
    logic [SEL_W-1:0]  w_sel;
    logic [XLEN-1:0]   w_data;

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_match
            assign w_match[k] = rs_used && ent_v[k] && ent_wen[k]
                             && (ent_rd[k*REG_AW +: REG_AW] == rs)
                             && (rs != '0);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching stage overwrites the rest
    always_comb begin
        w_hit   = 1'b0;
        w_ready = 1'b1;
        w_sel   = SEL_W'(SEL_RF);
        w_data  = rf_data;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit   = 1'b1;
                w_ready = !ent_ld[k] || (k >= LOAD_STAGE);
                w_sel   = SEL_W'(k + 1);
                w_data  = stage_data[k*XLEN +: XLEN];
            end
        end
    end

    assign fwd_sel   = (w_hit && w_ready) ? w_sel  : SEL_W'(SEL_RF);
    assign fwd_data  = (w_hit && w_ready) ? w_data : rf_data;
    assign not_ready = w_hit && !w_ready;

endmodule : pipe_hazard_fwd_mux
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Desc     : In-flight writer tracking, operand forwarding and stall control
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [REG_AW-1:0]             issue_rs1,
    input  logic [REG_AW-1:0]             issue_rs2,
    input  logic                          issue_rs1_used,
    input  logic                          issue_rs2_used,
    input  logic [REG_AW-1:0]             issue_rd,
    input  logic                          issue_wen,
    input  logic                          issue_is_load,
    input  logic                          flush,
    input  logic                          ext_stall,
    input  logic [NSTAGE*XLEN-1:0]        stage_data,
    input  logic [XLEN-1:0]               rf_rs1_data,
    input  logic [XLEN-1:0]               rf_rs2_data,
    output logic [XLEN-1:0]               fwd_rs1_data,
    output logic [XLEN-1:0]               fwd_rs2_data,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs1_sel,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs2_sel,
    output logic                          stall_id,
    output logic                          issue_fire,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int SEL_W = $clog2(NSTAGE + 1);

    logic [NSTAGE-1:0]        r_v;
    logic [NSTAGE-1:0]        r_wen;
    logic [NSTAGE-1:0]        r_ld;
    logic [NSTAGE*REG_AW-1:0] r_rd;
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [CNT_W-1:0]         r_flush_cnt;

    logic w_rs1_not_ready;
    logic w_rs2_not_ready;
    logic w_hazard;
    logic w_stall;
    logic w_fire;

    pipe_hazard_fwd_mux #(
        .XLEN       (XLEN),
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_fwd_rs1 (
        .rs         (issue_rs1),
        .rs_used    (issue_rs1_used),
        .ent_v      (r_v),
        .ent_wen    (r_wen),
        .ent_ld     (r_ld),
        .ent_rd     (r_rd),
        .stage_data (stage_data),
        .rf_data    (rf_rs1_data),
        .fwd_data   (fwd_rs1_data),
        .fwd_sel    (fwd_rs1_sel),
        .not_ready  (w_rs1_not_ready)
    );

    pipe_hazard_fwd_mux #(
        .XLEN       (XLEN),
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_fwd_rs2 (
        .rs         (issue_rs2),
        .rs_used    (issue_rs2_used),
        .ent_v      (r_v),
        .ent_wen    (r_wen),
        .ent_ld     (r_ld),
        .ent_rd     (r_rd),
        .stage_data (stage_data),
        .rf_data    (rf_rs2_data),
        .fwd_data   (fwd_rs2_data),
        .fwd_sel    (fwd_rs2_sel),
        .not_ready  (w_rs2_not_ready)
    );

    // A flushed instruction never stalls: the redirect takes priority
    assign w_hazard = issue_valid && !flush && (w_rs1_not_ready || w_rs2_not_ready);
    assign w_stall  = w_hazard || ext_stall;
    assign w_fire   = issue_valid && !flush && !w_stall;

    assign stall_id   = w_stall;
    assign issue_fire = w_fire;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_wen <= '0;
            r_ld  <= '0;
            r_rd  <= '0;
        end else if (!ext_stall) begin
            for (int k = 1; k < NSTAGE; k++) begin
                r_v[k]                  <= r_v[k-1];
                r_wen[k]                <= r_wen[k-1];
                r_ld[k]                 <= r_ld[k-1];
                r_rd[k*REG_AW +: REG_AW] <= r_rd[(k-1)*REG_AW +: REG_AW];
            end
            r_v[STG_EX]                       <= w_fire;
            r_wen[STG_EX]                     <= w_fire && issue_wen;
            r_ld[STG_EX]                      <= w_fire && issue_is_load;
            r_rd[STG_EX*REG_AW +: REG_AW]     <= w_fire ? issue_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush && issue_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Desc     : Directed vector and sequence bench for pipe_hazard_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [63:0] RF1 = 64'h1111;
    localparam logic [63:0] RF2 = 64'h2222;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue_valid, issue_rs1_used, issue_rs2_used;
    logic [4:0]   issue_rs1, issue_rs2, issue_rd;
    logic         issue_wen, issue_is_load, flush, ext_stall;
    logic [63:0]  sd0, sd1, sd2;
    logic [191:0] stage_data;
    logic [63:0]  rf_rs1_data, rf_rs2_data;

    logic [63:0]  fwd_rs1_data, fwd_rs2_data;
    logic [1:0]   fwd_rs1_sel, fwd_rs2_sel;
    logic         stall_id, issue_fire;
    logic [31:0]  stall_cnt, flush_cnt;

    logic [63:0]  s_fwd_rs1_data, s_fwd_rs2_data;
    logic [1:0]   s_fwd_rs1_sel, s_fwd_rs2_sel;
    logic         s_stall_id, s_issue_fire;
    logic [1:0]   s_stall_cnt, s_flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign stage_data = {sd2, sd1, sd0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_is_load(issue_is_load),
        .flush(flush), .ext_stall(ext_stall), .stage_data(stage_data),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_id(stall_id), .issue_fire(issue_fire),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance shares all inputs to exercise saturation quickly
    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_is_load(issue_is_load),
        .flush(flush), .ext_stall(ext_stall), .stage_data(stage_data),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_rs1_data(s_fwd_rs1_data), .fwd_rs2_data(s_fwd_rs2_data),
        .fwd_rs1_sel(s_fwd_rs1_sel), .fwd_rs2_sel(s_fwd_rs2_sel),
        .stall_id(s_stall_id), .issue_fire(s_issue_fire),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        wen, ld;
        logic [63:0] d0, d1, d2;
        logic [1:0]  e_sel1;
        logic [63:0] e_fwd1;
        logic [1:0]  e_sel2;
        logic [63:0] e_fwd2;
        logic        e_stall, e_fire;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mkv(
        input logic v, input logic [4:0] r1, input logic [4:0] r2,
        input logic a1, input logic a2, input logic [4:0] d,
        input logic w, input logic l,
        input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2,
        input logic [1:0] s1, input logic [63:0] f1,
        input logic [1:0] s2, input logic [63:0] f2,
        input logic st, input logic fi);
        vec_t t;
        t.valid = v;   t.rs1 = r1;   t.rs2 = r2;   t.u1 = a1;   t.u2 = a2;
        t.rd = d;      t.wen = w;    t.ld = l;
        t.d0 = x0;     t.d1 = x1;    t.d2 = x2;
        t.e_sel1 = s1; t.e_fwd1 = f1; t.e_sel2 = s2; t.e_fwd2 = f2;
        t.e_stall = st; t.e_fire = fi;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
        issue_rs1_used = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_wen = 0; issue_is_load = 0;
        flush = 0; ext_stall = 0; sd0 = 0; sd1 = 0; sd2 = 0;
    endtask

    task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] d, input logic w, input logic l,
                       input logic fl, input logic ex);
        issue_valid = v; issue_rs1 = r1; issue_rs1_used = u1;
        issue_rs2 = 0; issue_rs2_used = 0;
        issue_rd = d; issue_wen = w; issue_is_load = l;
        flush = fl; ext_stall = ex;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #3;
        rst_n = 1;
    endtask

    initial begin
        rf_rs1_data = RF1;
        rf_rs2_data = RF2;
        idle();
        rst_n = 0;
        #12;
        chk("rst_stall", stall_id, 0);
        chk("rst_sel1", fwd_rs1_sel, 0);
        chk("rst_fwd1", fwd_rs1_data, RF1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst_n = 1;
        tick();

        //           v  rs1 rs2 u1 u2 rd wen ld  sd0        sd1      sd2       sel1 fwd1      sel2 fwd2   stall fire
        tbl[0] = mkv(1, 1,  2,  1, 1, 5, 1, 0, 0,         0,       0,        0, RF1,       0, RF2,  0, 1);
        tbl[1] = mkv(1, 5,  6,  1, 1, 6, 1, 0, 64'h1234,  0,       0,        1, 64'h1234,  0, RF2,  0, 1);
        tbl[2] = mkv(1, 6,  5,  1, 1, 3, 1, 0, 64'h66,    64'h55,  0,        1, 64'h66,    2, 64'h55, 0, 1);
        tbl[3] = mkv(1, 5,  0,  1, 1, 0, 1, 0, 0,         0,       64'h5555, 3, 64'h5555,  0, RF2,  0, 1);
        tbl[4] = mkv(1, 0,  3,  1, 1, 3, 1, 0, 0,         64'h33,  0,        0, RF1,       2, 64'h33, 0, 1);
        tbl[5] = mkv(0, 3,  3,  1, 0, 0, 0, 0, 64'hAA,    0,       64'hBB,   1, 64'hAA,    0, RF2,  0, 0);
        tbl[6] = mkv(0, 3,  0,  1, 0, 0, 0, 0, 0,         64'h77,  0,        2, 64'h77,    0, RF2,  0, 0);
        tbl[7] = mkv(1, 3,  0,  1, 0, 7, 0, 0, 0,         0,       64'h99,   3, 64'h99,    0, RF2,  0, 1);
        tbl[8] = mkv(1, 7,  3,  1, 1, 0, 0, 0, 0,         0,       0,        0, RF1,       0, RF2,  0, 1);

        for (int i = 0; i < 9; i++) begin
            issue_valid = tbl[i].valid; issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2;
            issue_rs1_used = tbl[i].u1; issue_rs2_used = tbl[i].u2;
            issue_rd = tbl[i].rd; issue_wen = tbl[i].wen; issue_is_load = tbl[i].ld;
            sd0 = tbl[i].d0; sd1 = tbl[i].d1; sd2 = tbl[i].d2;
            #1;
            chk($sformatf("v%0d_sel1", i), fwd_rs1_sel, tbl[i].e_sel1);
            chk($sformatf("v%0d_fwd1", i), fwd_rs1_data, tbl[i].e_fwd1);
            chk($sformatf("v%0d_sel2", i), fwd_rs2_sel, tbl[i].e_sel2);
            chk($sformatf("v%0d_fwd2", i), fwd_rs2_data, tbl[i].e_fwd2);
            chk($sformatf("v%0d_stall", i), stall_id, tbl[i].e_stall);
            chk($sformatf("v%0d_fire", i), issue_fire, tbl[i].e_fire);
            tick();
        end
        chk("vec_stall_cnt", stall_cnt, 0);

        // Load-use: two stall cycles, then forward from WB
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0, 0);
        #1 chk("lu_ld_fire", issue_fire, 1);
        tick();
        drv(1, 7, 1, 8, 1, 0, 0, 0);
        sd2 = 64'hDEAD_BEEF;
        #1 chk("lu_stall_a", stall_id, 1);
        chk("lu_fire_a", issue_fire, 0);
        tick();
        chk("lu_stall_b", stall_id, 1);
        tick();
        chk("lu_stall_c", stall_id, 0);
        chk("lu_sel", fwd_rs1_sel, 3);
        chk("lu_fwd", fwd_rs1_data, 64'hDEAD_BEEF);
        chk("lu_fire_c", issue_fire, 1);
        chk("lu_stall_cnt", stall_cnt, 2);
        tick();

        // Flush beats a pending hazard and leaves a bubble
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0, 0);
        tick();
        drv(1, 7, 1, 9, 1, 0, 1, 0);
        #1 chk("fl_stall", stall_id, 0);
        chk("fl_fire", issue_fire, 0);
        tick();
        drv(1, 9, 1, 10, 1, 0, 0, 0);
        #1 chk("fl_flush_cnt", flush_cnt, 1);
        chk("fl_bubble_sel", fwd_rs1_sel, 0);
        chk("fl_bubble_fwd", fwd_rs1_data, RF1);
        chk("fl_stall_cnt", stall_cnt, 0);
        tick();

        // ext_stall freezes entries; load-use still needs two more cycles
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0, 0);
        tick();
        drv(1, 7, 1, 8, 1, 0, 0, 1);
        sd2 = 64'hCAFE;
        repeat (3) begin
            #1 chk("ex_stall", stall_id, 1);
            chk("ex_fire", issue_fire, 0);
            chk("ex_sel", fwd_rs1_sel, 0);
            tick();
        end
        ext_stall = 0;
        #1 chk("ex_rel_stall_a", stall_id, 1);
        tick();
        chk("ex_rel_stall_b", stall_id, 1);
        tick();
        chk("ex_rel_stall_c", stall_id, 0);
        chk("ex_rel_sel", fwd_rs1_sel, 3);
        chk("ex_rel_fwd", fwd_rs1_data, 64'hCAFE);
        chk("ex_stall_cnt", stall_cnt, 5);
        chk("sat_stall_cnt", s_stall_cnt, 2'b11);
        tick();

        // Asynchronous reset in the middle of a stall
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0, 0);
        tick();
        drv(1, 7, 1, 8, 1, 0, 0, 0);
        #1 chk("ar_stall_pre", stall_id, 1);
        tick();
        chk("ar_cnt_pre", stall_cnt, 1);
        rst_n = 0;
        #1 chk("ar_stall", stall_id, 0);
        chk("ar_sel", fwd_rs1_sel, 0);
        chk("ar_fwd", fwd_rs1_data, RF1);
        chk("ar_stall_cnt", stall_cnt, 0);
        chk("ar_flush_cnt", flush_cnt, 0);
        #2 rst_n = 1;
        idle();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RV64 pipeline.
- Replaces the fixed two-source forward mux and the single-stage load-use bubble logic.
- Tracks every in-flight writer across NSTAGE post-issue stages (EX..WB) in a shift register, forwards the youngest ready result to the ID operands, and raises a stall when the youngest matching producer is not ready yet.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
- XLEN, 64, datapath width.
- REG_AW, 5, register address width.
- NSTAGE, 3, tracked stages after issue; index 0=EX, NSTAGE-1=WB.
- LOAD_STAGE, 2, first stage index where load data is valid. Must satisfy 1 <= LOAD_STAGE <= NSTAGE-1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID holds a valid instruction.
- issue_rs1, issue_rs2  in  REG_AW  source register addresses.
- issue_rs1_used, issue_rs2_used  in  1  source is actually read.
- issue_rd  in  REG_AW  destination register.
- issue_wen  in  1  instruction writes rd.
- issue_is_load  in  1  result comes from memory.
- flush  in  1  EX redirect; kills the ID instruction.
- ext_stall  in  1  memory or bus busy; freezes all tracked stages.
- stage_data  in  NSTAGE*XLEN  result of stage k at bits [k*XLEN +: XLEN].
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data.
- fwd_rs1_data, fwd_rs2_data  out  XLEN  operands for capture into ID/EX.
- fwd_rs1_sel, fwd_rs2_sel  out  $clog2(NSTAGE+1)  0 = register file, k+1 = stage k.
- stall_id  out  1  hold IF/ID and the PC.
- issue_fire  out  1  ID instruction enters stage 0 this cycle.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Tracking state: per stage k, an entry {v, rd, wen, ld}.
- Reset (async, rst_n=0): all v=0, counters=0. With entries invalid, stall_id=0, sel=0 and fwd=rf data.
- Match for stage k on rsN: rsN_used && v[k] && wen[k] && rd[k]==rsN && rsN!=0.
- Priority: the lowest k (youngest) among matches wins. Older matches are ignored.
- Ready: winning stage k is ready iff !ld[k] || k>=LOAD_STAGE.
- If the winner is ready: sel=k+1 and fwd=stage_data[k].
- No match: sel=0, fwd=rf data.
- hazard = issue_valid && !flush && (rs1 winner not ready || rs2 winner not ready).
- stall_id = hazard || ext_stall. This output is combinational.
- issue_fire = issue_valid && !flush && !stall_id.
- On clk rise with ext_stall=1: all entries hold. New issues and flushes are not recorded into entries.
- On clk rise with ext_stall=0:
  - entry[k] <= entry[k-1] for k>=1.
  - entry[0] <= issue_fire ? {1, issue_rd, issue_wen, issue_is_load} : bubble (v=0).
- Flush and hazard in the same cycle: flush wins, hazard=0, and a bubble is inserted.
- stall_cnt increments each cycle stall_id=1. flush_cnt increments each cycle flush=1 && issue_valid.
  - Both saturate at all-ones and never wrap.
- The RF write occurs at the end of WB. A same-cycle reader is covered by the stage NSTAGE-1 forward, so no RF write-through is required.
- A load-use dependency stalls exactly LOAD_STAGE cycles when the load is in stage 0 with no ext_stall.

Decomposition:
- Shared package: stage index constants (STG_EX=0, STG_ME=1, STG_WB=2), fwd_sel encoding (SEL_RF=0), and the entry field widths.
- One sub-module: pipe_hazard_fwd_mux. It is a combinational priority match plus mux for one source, instantiated twice (rs1, rs2).

Test Plan:
- Back-to-back ALU ops: add x5 issued, then the next instruction reads x5 with stage_data[0]=0x1234 -> sel=1, fwd=0x1234, stall_id=0.
- Load-use: ld x7 in stage 0, reader of x7 in ID:
  - stall_id=1 for 2 cycles.
  - Then sel=3 and fwd=stage_data[2]=0xDEAD_BEEF.
  - stall_cnt=2.
- Two in-flight writers to x3, in stage 0 (0xAA) and stage 2 (0xBB) -> fwd=0xAA, sel=1. A read of x0 with x0 "written" -> sel=0, fwd=rf data.
- flush with issue_valid, while a hazard is pending -> stall_id=0, issue_fire=0, entry[0].v=0 next cycle, flush_cnt=1.
- ext_stall high for 3 cycles with a load in stage 0:
  - Entries are frozen and stall_id=1.
  - After release, the load-use stall still lasts 2 more cycles.
- Assert rst_n low mid-stall -> entries are cleared immediately (async), stall_id=0 and the counters read 0.
- Preload stall_cnt to 0xFFFF_FFFE and stall 3 cycles -> the counter stays at 0xFFFF_FFFF.
